sm_operand_sequencer: RTL and testbench



---
 rtl/sm_pkg.sv | 33 +++
 rtl/sm_operand_sequencer_tc_to_sm.sv | 38 +++
 rtl/sm_operand_sequencer.sv | 139 +++++++++++++
 tb/tb_sm_operand_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude operand sequencer.
//   state_e       : sequencer FSM states (capture A, capture B, add, present)
//   sm_max_mag    : largest magnitude representable in an n-bit sign-magnitude word
//   sm_norm_zero  : turns a negative zero (sign set, magnitude zero) into all zeros
// Helpers work on MAX_N-bit containers so they can serve any word width N < MAX_N.
package sm_pkg;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_ADD = 2'd2,
    S_OUT = 2'd3
  } state_e;

  localparam int unsigned MAX_N = 32;

  function automatic int unsigned sm_max_mag(input int unsigned n);
    return (32'd1 << (n - 32'd1)) - 32'd1;
  endfunction

  // v holds an n-bit sign-magnitude word, zero-extended to MAX_N bits.
  function automatic logic [MAX_N-1:0] sm_norm_zero(input logic [MAX_N-1:0] v,
                                                    input int unsigned n);
    logic [MAX_N-1:0] mask;
    mask = MAX_N'(sm_max_mag(n));
    if ((v & mask) == {MAX_N{1'b0}}) begin
      return {MAX_N{1'b0}};
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/sm_operand_sequencer_tc_to_sm.sv
// tc_to_sm: combinational two's-complement to sign-magnitude conversion.
// Ports:
//   x   in  N  two's-complement word
//   y   out N  sign-magnitude word (bit N-1 sign, N-2:0 magnitude)
//   sat out 1  x was the most negative value and was clamped to -(2^(N-1)-1)
module tc_to_sm
  import sm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic         sat
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  // Low N-1 bits of -x only depend on the low N-1 bits of x.
  logic [N-2:0] neg_mag_s;
  assign neg_mag_s = (~x[N-2:0]) + (N-1)'(1);

  // Select pass-through, negate, or clamp.
  always_comb begin
    y   = x;
    sat = 1'b0;
    if (x[N-1] == 1'b0) begin
      y   = x;
      sat = 1'b0;
    end else if (x == MOST_NEG) begin
      y   = {1'b1, {(N-1){1'b1}}};
      sat = 1'b1;
    end else begin
      y   = {1'b1, neg_mag_s};
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/sm_operand_sequencer.sv
// sm_operand_sequencer: pairs a stream of two's-complement words into
// sign-magnitude operands for an external combinational sign_adder, then
// captures, normalises and flags the adder's sum.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake, in_data N-bit two's-complement word
//   op_a, op_b          registered sign-magnitude operands to the adder
//   sum_in              sign-magnitude sum returned by the adder
//   out_valid/out_ready result handshake
//   out_sum             normalised result (never negative zero)
//   out_ovf             same-sign magnitudes overflowed; out_sum is wrapped
//   out_sat             one of the inputs was clamped during conversion
// One result every 4 cycles at best: A, B, ADD, OUT.
module sm_operand_sequencer
  import sm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  input  logic [N-1:0] sum_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf,
  output logic         out_sat
);

  localparam logic [N-1:0] MAX_MAG = N'(sm_max_mag(32'(N)));

  state_e       state_r;
  state_e       state_nxt_s;
  logic [N-1:0] conv_s;
  logic         conv_sat_s;
  logic [N-1:0] op_a_r;
  logic [N-1:0] op_b_r;
  logic         sat_a_r;
  logic         sat_b_r;
  logic [N-1:0] out_sum_r;
  logic         out_ovf_r;
  logic         out_sat_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [N-1:0] mag_sum_s;
  logic         ovf_s;
  logic [MAX_N-1:0] norm_wide_s;
  logic         unused_norm_s;

  tc_to_sm #(.N(N)) u_tc_to_sm (
    .x   (in_data),
    .y   (conv_s),
    .sat (conv_sat_s)
  );

  // Magnitude sum at N bits so the carry out of the N-1 bit magnitude is visible.
  assign mag_sum_s = {1'b0, op_a_r[N-2:0]} + {1'b0, op_b_r[N-2:0]};
  assign ovf_s     = (op_a_r[N-1] == op_b_r[N-1]) && (mag_sum_s > MAX_MAG);

  assign norm_wide_s   = sm_norm_zero(MAX_N'(sum_in), 32'(N));
  assign unused_norm_s = |norm_wide_s[MAX_N-1:N];

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_A: begin
        if (in_valid) state_nxt_s = S_B;
        else          state_nxt_s = S_A;
      end
      S_B: begin
        if (in_valid) state_nxt_s = S_ADD;
        else          state_nxt_s = S_B;
      end
      S_ADD: state_nxt_s = S_OUT;
      S_OUT: begin
        if (out_ready) state_nxt_s = S_A;
        else           state_nxt_s = S_OUT;
      end
      default: state_nxt_s = S_A;
    endcase
  end

  // State register and Moore handshake flags, registered from the next state
  // so neither flag has a path from in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_A;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == S_A) || (state_nxt_s == S_B);
      out_valid_r <= (state_nxt_s == S_OUT);
    end
  end

  // Operand capture; operands hold through ADD and OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r  <= {N{1'b0}};
      op_b_r  <= {N{1'b0}};
      sat_a_r <= 1'b0;
      sat_b_r <= 1'b0;
    end else if (state_r == S_A && in_valid) begin
      op_a_r  <= conv_s;
      sat_a_r <= conv_sat_s;
    end else if (state_r == S_B && in_valid) begin
      op_b_r  <= conv_s;
      sat_b_r <= conv_sat_s;
    end
  end

  // Result capture at the end of the ADD cycle; held until the next ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum_r <= {N{1'b0}};
      out_ovf_r <= 1'b0;
      out_sat_r <= 1'b0;
    end else if (state_r == S_ADD) begin
      out_sum_r <= norm_wide_s[N-1:0];
      out_ovf_r <= ovf_s;
      out_sat_r <= sat_a_r | sat_b_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign op_a      = op_a_r;
  assign op_b      = op_b_r;
  assign out_sum   = out_sum_r;
  assign out_ovf   = out_ovf_r;
  assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_sm_operand_sequencer.sv
// Bench for sm_operand_sequencer with a behavioural stand-in for sign_adder.
// Expected results come from signed-integer arithmetic and are queued at issue;
// a monitor pops and compares on every output handshake.
module tb_sm_operand_sequencer;

  localparam int N    = 4;
  localparam int MAXM = (1 << (N - 1)) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] sum_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_ovf;
  logic         out_sat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic [N-1:0] sum;
    logic         ovf;
    logic         sat;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

  // Sign-magnitude adder: same sign adds magnitudes (carry dropped), otherwise
  // subtracts; on equal magnitudes the sign of b wins (can give negative zero).
  function automatic logic [N-1:0] adder(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-2:0] ma;
    logic [N-2:0] mb;
    ma = a[N-2:0];
    mb = b[N-2:0];
    if (a[N-1] == b[N-1]) return {a[N-1], ma + mb};
    else if (ma > mb)     return {a[N-1], ma - mb};
    else                  return {b[N-1], mb - ma};
  endfunction

  assign sum_in = adder(op_a, op_b);

  sm_operand_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op_a      (op_a),
    .op_b      (op_b),
    .sum_in    (sum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_sat   (out_sat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] to_sm(input int v);
    logic [N-1:0] t;
    t = N'(v < 0 ? -v : v);
    if (v < 0) t[N-1] = 1'b1;
    return t;
  endfunction

  // Reference: clamp, add as integers, wrap magnitude only on same-sign overflow.
  function automatic exp_t model(input int wa, input int wb);
    exp_t e;
    int   va, vb, ma, mb, mag, r;
    bit   na, nb, sign;
    e.sat = 1'b0;
    va = wa;
    vb = wb;
    if (va == -(MAXM + 1)) begin va = -MAXM; e.sat = 1'b1; end
    if (vb == -(MAXM + 1)) begin vb = -MAXM; e.sat = 1'b1; end
    e.opa = to_sm(va);
    e.opb = to_sm(vb);
    ma = va < 0 ? -va : va;
    mb = vb < 0 ? -vb : vb;
    na = va < 0;
    nb = vb < 0;
    if (na == nb && ma + mb > MAXM) begin
      e.ovf = 1'b1;
      mag   = (ma + mb) % (MAXM + 1);
      sign  = na;
    end else begin
      e.ovf = 1'b0;
      r     = va + vb;
      sign  = r < 0;
      mag   = r < 0 ? -r : r;
    end
    if (mag == 0) e.sum = '0;
    else begin
      e.sum = N'(mag);
      e.sum[N-1] = sign;
    end
    return e;
  endfunction

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got sum %0h with no expectation queued", out_sum);
      end else begin
        e = expq.pop_front();
        check("op_a", op_a, e.opa);
        check("op_b", op_b, e.opb);
        check("out_sum", out_sum, e.sum);
        check("out_ovf", out_ovf, e.ovf);
        check("out_sat", out_sat, e.sat);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input int w);
    int cnt;
    in_valid = 1'b1;
    in_data  = N'(w);
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = N'($urandom);
  endtask

  task automatic do_pair(input int wa, input int wb, input int gap, input int stall);
    exp_t e;
    e = model(wa, wb);
    idle(gap);
    send_word(wa);
    idle(gap);
    expq.push_back(e);
    send_word(wb);
    out_ready = 1'b0;
    check("add_out_valid", out_valid, 0);
    check("add_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("res_out_valid", out_valid, 1);
    check("res_in_ready", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", out_sum, e.sum);
      check("hold_ovf", out_ovf, e.ovf);
      check("hold_sat", out_sat, e.sat);
      check("hold_op_a", op_a, e.opa);
      check("hold_op_b", op_b, e.opb);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'($urandom);
    check("back_in_ready", in_ready, 1);
    check("back_out_valid", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    idle(3);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_sat", out_sat, 0);

    do_pair(3, 2, 0, 0);
    do_pair(3, -3, 0, 0);
    do_pair(-8, 1, 0, 0);
    do_pair(5, 4, 0, 0);
    do_pair(-5, 4, 1, 0);
    do_pair(-8, -8, 0, 1);
    do_pair(2, 1, 0, 3);

    // Reset while waiting for B discards the partial pair.
    send_word(6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_op_a", op_a, 0);
    check("midrst_op_b", op_b, 0);
    do_pair(1, 1, 0, 0);

    for (int k = 0; k < 40; k++) begin
      do_pair(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    idle(2);
    check("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
